axi_sram_slave: RTL and testbench

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

---
 rtl/axi_sram_if.sv | 42 ++++
 rtl/axi_sram_slave.sv | 176 +++++++++++++++++
 tb/tb_axi_sram_slave.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_sram_if.sv
// AXI-style read/write channel bundle between a bus master and the SRAM slave.
interface axi_sram_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;
   logic [3:0]  awid;
   logic [31:0] awaddr;
   logic [3:0]  awlen;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        wvalid;
   logic        wready;
   logic [3:0]  bid;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport slave (
      input  arid, araddr, arlen, arvalid, rready,
      input  awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
      output arready, rid, rdata, rresp, rlast, rvalid,
      output awready, wready, bid, bresp, bvalid
   );

   modport master (
      output arid, araddr, arlen, arvalid, rready,
      output awid, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready,
      input  arready, rid, rdata, rresp, rlast, rvalid,
      input  awready, wready, bid, bresp, bvalid
   );
endinterface

// File: rtl/axi_sram_slave.sv
// Single-outstanding AXI-style SRAM slave: INCR bursts of 32-bit words,
// byte-strobed writes, wlast cross-checked against awlen for the B response.
module axi_sram_slave #(
   parameter int unsigned IDX_W = 12
) (
   input  logic       clk,
   input  logic       rst,
   axi_sram_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** IDX_W;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_READ  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_WRESP = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d, idx_inc;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0]       id_q, id_d;
   logic             err_q, err_d, err_now;
   logic             rvalid_q, rvalid_d;
   logic             rlast_q, rlast_d;
   logic [3:0]       rid_q, rid_d;
   logic [31:0]      rdata_q, rdata_d;
   logic             wready_q, wready_d;
   logic             bvalid_q, bvalid_d;
   logic [3:0]       bid_q, bid_d;
   logic [1:0]       bresp_q, bresp_d;
   logic             we_c;
   logic             unused_c;

   logic [31:0] mem_q [DEPTH];

   assign idx_inc = idx_q + IDX_W'(1);

   // Next-state and registered-output computation.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      id_d     = id_q;
      err_d    = err_q;
      err_now  = err_q;
      rvalid_d = rvalid_q;
      rlast_d  = rlast_q;
      rid_d    = rid_q;
      rdata_d  = rdata_q;
      wready_d = wready_q;
      bvalid_d = bvalid_q;
      bid_d    = bid_q;
      bresp_d  = bresp_q;
      we_c     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.awvalid) begin
               state_d  = S_WRITE;
               idx_d    = bus.awaddr[IDX_W+1:2];
               cnt_d    = bus.awlen;
               id_d     = bus.awid;
               err_d    = 1'b0;
               wready_d = 1'b1;
            end else if (bus.arvalid) begin
               state_d  = S_READ;
               idx_d    = bus.araddr[IDX_W+1:2];
               cnt_d    = bus.arlen[3:0];
               rid_d    = bus.arid;
               rvalid_d = 1'b1;
               rdata_d  = mem_q[bus.araddr[IDX_W+1:2]];
               rlast_d  = (bus.arlen[3:0] == 4'd0);
            end
         end
         S_READ: begin
            if (bus.rready) begin
               if (rlast_q) begin
                  state_d  = S_IDLE;
                  rvalid_d = 1'b0;
                  rlast_d  = 1'b0;
                  rid_d    = 4'd0;
                  rdata_d  = 32'd0;
               end else begin
                  idx_d   = idx_inc;
                  cnt_d   = cnt_q - 4'd1;
                  rdata_d = mem_q[idx_inc];
                  rlast_d = (cnt_q == 4'd1);
               end
            end
         end
         S_WRITE: begin
            if (bus.wvalid) begin
               we_c    = 1'b1;
               // Burst length comes from awlen; wlast is only checked.
               err_now = err_q | (bus.wlast != (cnt_q == 4'd0));
               err_d   = err_now;
               if (cnt_q == 4'd0) begin
                  state_d  = S_WRESP;
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bid_d    = id_q;
                  bresp_d  = err_now ? 2'b10 : 2'b00;
               end else begin
                  idx_d = idx_inc;
                  cnt_d = cnt_q - 4'd1;
               end
            end
         end
         S_WRESP: begin
            if (bus.bready) begin
               state_d  = S_IDLE;
               bvalid_d = 1'b0;
               bid_d    = 4'd0;
               bresp_d  = 2'b00;
               err_d    = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         cnt_q    <= 4'd0;
         id_q     <= 4'd0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         rid_q    <= 4'd0;
         rdata_q  <= 32'd0;
         wready_q <= 1'b0;
         bvalid_q <= 1'b0;
         bid_q    <= 4'd0;
         bresp_q  <= 2'b00;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         id_q     <= id_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
         rlast_q  <= rlast_d;
         rid_q    <= rid_d;
         rdata_q  <= rdata_d;
         wready_q <= wready_d;
         bvalid_q <= bvalid_d;
         bid_q    <= bid_d;
         bresp_q  <= bresp_d;
      end
   end

   // Storage is not reset; a reset only abandons the burst in flight.
   always_ff @(posedge clk) begin
      if (we_c && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.wstrb[b]) mem_q[idx_q][8*b +: 8] <= bus.wdata[8*b +: 8];
         end
      end
   end

   assign bus.awready = (state_q == S_IDLE) & ~rst;
   assign bus.arready = (state_q == S_IDLE) & ~rst & ~bus.awvalid;
   assign bus.rvalid  = rvalid_q;
   assign bus.rlast   = rlast_q;
   assign bus.rid     = rid_q;
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = 2'b00;
   assign bus.wready  = wready_q;
   assign bus.bvalid  = bvalid_q;
   assign bus.bid     = bid_q;
   assign bus.bresp   = bresp_q;

   assign unused_c = ^{bus.arlen[7:4], bus.araddr[1:0], bus.araddr[31:IDX_W+2],
                       bus.awaddr[1:0], bus.awaddr[31:IDX_W+2]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised self-checking bench for axi_sram_slave against a word-array memory model.
module tb_axi_sram_slave;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   axi_sram_if bus ();
   axi_sram_slave #(.IDX_W(12)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [31:0] mm [4096];
   logic [31:0] wd [16];
   logic [3:0]  ws [16];
   bit          wl [16];
   logic [31:0] rd_data [16];
   logic        rd_last [16];
   logic [3:0]  rd_id [16];
   logic [1:0]  br;
   logic [3:0]  bi;
   bit          to, lat, stab, endk;

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic void model_write(input logic [31:0] addr, input int len);
      int idx = int'(addr[13:2]);
      for (int b = 0; b <= len; b++) begin
         for (int k = 0; k < 4; k++)
            if (ws[b][k]) mm[idx][8*k +: 8] = wd[b][8*k +: 8];
         idx = (idx + 1) % 4096;
      end
   endfunction

   function automatic logic [1:0] exp_bresp(input int len);
      bit e = 0;
      for (int b = 0; b <= len; b++) if (wl[b] != (b == len)) e = 1;
      return e ? 2'b10 : 2'b00;
   endfunction

   function automatic void fill_normal(input int len);
      for (int b = 0; b < 16; b++) begin
         wd[b] = $urandom; ws[b] = 4'hF; wl[b] = (b == len);
      end
   endfunction

   task automatic axi_write(input logic [31:0] addr, input int len, input logic [3:0] id,
                            output logic [1:0] bresp_o, output logic [3:0] bid_o, output bit to_o);
      int n;
      to_o = 0;
      bus.awid = id; bus.awaddr = addr; bus.awlen = 4'(len); bus.awvalid = 1'b1;
      #1; n = 0;
      while (bus.awready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) to_o = 1;
      @(posedge clk); @(negedge clk);
      bus.awvalid = 1'b0;
      for (int b = 0; b <= len; b++) begin
         bus.wvalid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
         bus.wdata = wd[b]; bus.wstrb = ws[b]; bus.wlast = wl[b]; bus.wvalid = 1'b1;
         n = 0;
         while (bus.wready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         if (n >= 20) to_o = 1;
         @(negedge clk);
      end
      bus.wvalid = 1'b0; bus.wlast = 1'b0;
      n = 0;
      while (bus.bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      if (n >= 20) to_o = 1;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bresp_o = bus.bresp; bid_o = bus.bid;
      bus.bready = 1'b1; @(negedge clk); bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [31:0] addr, input int len, input logic [3:0] id,
                           input int stall, output bit to_o, output bit lat_o,
                           output bit stab_o, output bit end_o);
      int n;
      logic [31:0] d; logic l; logic [3:0] i;
      to_o = 0; stab_o = 1;
      bus.arid = id; bus.araddr = addr; bus.arlen = {4'($urandom), 4'(len)}; bus.arvalid = 1'b1;
      #1; n = 0;
      while (bus.arready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) to_o = 1;
      @(posedge clk); @(negedge clk);
      bus.arvalid = 1'b0;
      lat_o = (bus.rvalid === 1'b1);
      for (int b = 0; b <= len; b++) begin
         n = 0;
         while (bus.rvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
         if (n >= 20) to_o = 1;
         d = bus.rdata; l = bus.rlast; i = bus.rid;
         repeat ((stall < 0) ? $urandom_range(0, 2) : stall) begin
            @(negedge clk);
            if (bus.rdata !== d || bus.rlast !== l || bus.rid !== i || bus.rvalid !== 1'b1) stab_o = 0;
         end
         rd_data[b] = bus.rdata; rd_last[b] = bus.rlast; rd_id[b] = bus.rid;
         bus.rready = 1'b1; @(negedge clk); bus.rready = 1'b0;
      end
      end_o = (bus.rvalid === 1'b0);
   endtask

   task automatic test_reset;
      rst = 1'b1; bus.awvalid = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if ({bus.awready, bus.arready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {bus.awready, bus.arready}); end
      checks++; if ({bus.rvalid, bus.rlast, bus.wready, bus.bvalid} !== 4'b0) begin failures++; $display("FAIL reset_valids got=%b exp=0000", {bus.rvalid, bus.rlast, bus.wready, bus.bvalid}); end
      checks++; if ({bus.rid, bus.bid, bus.rdata, bus.rresp, bus.bresp} !== 44'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus.rid, bus.bid, bus.rdata, bus.rresp, bus.bresp}); end
      bus.awvalid = 1'b0; rst = 1'b0; #1;
      checks++; if ({bus.awready, bus.arready} !== 2'b11) begin failures++; $display("FAIL idle_ready got=%b exp=11", {bus.awready, bus.arready}); end
   endtask

   task automatic init_region;
      for (int k = 0; k < 16; k++) begin
         fill_normal(15);
         axi_write(32'(k * 64), 15, 4'(k), br, bi, to); model_write(32'(k * 64), 15);
         checks++; if (to || br !== 2'b00) begin failures++; $display("FAIL init_bresp to=%0d got=%b exp=00", to, br); end
      end
   endtask

   task automatic test_single_read;
      fill_normal(0);
      axi_write(32'h100, 0, 4'h3, br, bi, to); model_write(32'h100, 0);
      axi_read(32'h100, 0, 4'h5, 0, to, lat, stab, endk);
      checks++; if (to || lat !== 1'b1) begin failures++; $display("FAIL single_latency to=%0d got=%0d exp=1", to, lat); end
      checks++; if (rd_data[0] !== mm[12'h040]) begin failures++; $display("FAIL single_data got=%h exp=%h", rd_data[0], mm[12'h040]); end
      checks++; if (rd_last[0] !== 1'b1 || rd_id[0] !== 4'h5) begin failures++; $display("FAIL single_last_id got=%b/%h exp=1/5", rd_last[0], rd_id[0]); end
      #1;
      checks++; if (endk !== 1'b1 || bus.arready !== 1'b1) begin failures++; $display("FAIL single_idle got=%0d/%b exp=1/1", endk, bus.arready); end
   endtask

   task automatic test_burst;
      for (int b = 0; b < 4; b++) begin wd[b] = 32'(8'h11 * (b + 1)); ws[b] = 4'hF; wl[b] = (b == 3); end
      axi_write(32'h200, 3, 4'h9, br, bi, to); model_write(32'h200, 3);
      checks++; if (to || br !== 2'b00 || bi !== 4'h9) begin failures++; $display("FAIL burst_b got=%b/%h exp=00/9", br, bi); end
      axi_read(32'h200, 3, 4'hA, -1, to, lat, stab, endk);
      for (int b = 0; b < 4; b++) begin
         checks++; if (rd_data[b] !== 32'(8'h11 * (b + 1)) || rd_last[b] !== (b == 3)) begin
            failures++; $display("FAIL burst_beat%0d got=%h/%b exp=%h/%b", b, rd_data[b], rd_last[b], 32'(8'h11 * (b + 1)), (b == 3)); end
      end
   endtask

   task automatic test_strobe;
      wd[0] = 32'h12345678; ws[0] = 4'hF; wl[0] = 1;
      axi_write(32'h0, 0, 4'h1, br, bi, to); model_write(32'h0, 0);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
      axi_write(32'h0, 0, 4'h1, br, bi, to); model_write(32'h0, 0);
      axi_read(32'h0, 0, 4'h2, -1, to, lat, stab, endk);
      checks++; if (to || rd_data[0] !== 32'h12BB56DD) begin failures++; $display("FAIL strobe_data got=%h exp=12bb56dd", rd_data[0]); end
   endtask

   task automatic test_collision;
      int n;
      wd[0] = $urandom; ws[0] = 4'hF; wl[0] = 1;
      bus.awid = 4'h6; bus.awaddr = 32'h40; bus.awlen = 4'd0; bus.awvalid = 1'b1;
      bus.arid = 4'hC; bus.araddr = 32'h40; bus.arlen = 8'd0; bus.arvalid = 1'b1;
      #1;
      checks++; if ({bus.awready, bus.arready} !== 2'b10) begin failures++; $display("FAIL collide_ready got=%b exp=10", {bus.awready, bus.arready}); end
      @(posedge clk); @(negedge clk);
      bus.awvalid = 1'b0; #1;
      checks++; if (bus.arready !== 1'b0) begin failures++; $display("FAIL collide_ar_blocked got=%b exp=0", bus.arready); end
      bus.wdata = wd[0]; bus.wstrb = 4'hF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
      @(negedge clk); bus.wvalid = 1'b0; bus.wlast = 1'b0;
      model_write(32'h40, 0);
      n = 0; while (bus.bvalid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++; if (bus.bvalid !== 1'b1 || bus.bid !== 4'h6) begin failures++; $display("FAIL collide_b got=%b/%h exp=1/6", bus.bvalid, bus.bid); end
      bus.bready = 1'b1; @(negedge clk); bus.bready = 1'b0; #1;
      checks++; if (bus.arready !== 1'b1) begin failures++; $display("FAIL collide_ar_after got=%b exp=1", bus.arready); end
      @(posedge clk); @(negedge clk); bus.arvalid = 1'b0;
      checks++; if (bus.rvalid !== 1'b1 || bus.rdata !== mm[16] || bus.rid !== 4'hC) begin
         failures++; $display("FAIL collide_read got=%b/%h/%h exp=1/%h/c", bus.rvalid, bus.rdata, bus.rid, mm[16]); end
      bus.rready = 1'b1; @(negedge clk); bus.rready = 1'b0;
   endtask

   task automatic test_wlast_err;
      for (int c = 0; c < 3; c++) begin
         fill_normal(1);
         if (c == 0) wl[0] = 1;
         if (c == 1) wl[1] = 0;
         axi_write(32'h300, 1, 4'(c), br, bi, to); model_write(32'h300, 1);
         checks++; if (to || br !== exp_bresp(1)) begin failures++; $display("FAIL wlast_case%0d got=%b exp=%b", c, br, exp_bresp(1)); end
         axi_read(32'h300, 1, 4'h7, -1, to, lat, stab, endk);
         checks++; if (rd_data[0] !== mm[192] || rd_data[1] !== mm[193]) begin
            failures++; $display("FAIL wlast_data%0d got=%h,%h exp=%h,%h", c, rd_data[0], rd_data[1], mm[192], mm[193]); end
      end
   endtask

   task automatic test_stall;
      axi_read(32'h180, 1, 4'hE, 5, to, lat, stab, endk);
      checks++; if (to || stab !== 1'b1) begin failures++; $display("FAIL stall_stable got=%0d exp=1", stab); end
      checks++; if (rd_data[1] !== mm[97] || rd_last[0] !== 1'b0 || rd_last[1] !== 1'b1) begin
         failures++; $display("FAIL stall_data got=%h/%b%b exp=%h/01", rd_data[1], rd_last[0], rd_last[1], mm[97]); end
   endtask

   task automatic test_wrap;
      fill_normal(2);
      axi_write(32'h5A5A_7FFD, 2, 4'h4, br, bi, to); model_write(32'h5A5A_7FFD, 2);
      axi_read(32'h0000_3FFC, 2, 4'h8, -1, to, lat, stab, endk);
      checks++; if (to || rd_data[0] !== wd[0] || rd_data[1] !== wd[1] || rd_data[2] !== wd[2]) begin
         failures++; $display("FAIL wrap_data got=%h,%h,%h exp=%h,%h,%h", rd_data[0], rd_data[1], rd_data[2], wd[0], wd[1], wd[2]); end
      checks++; if (mm[0] !== wd[1]) begin failures++; $display("FAIL wrap_model got=%h exp=%h", mm[0], wd[1]); end
   endtask

   task automatic test_reset_mid;
      int n;
      bus.arid = 4'h2; bus.araddr = 32'h100; bus.arlen = 8'd3; bus.arvalid = 1'b1;
      #1; n = 0; while (bus.arready !== 1'b1 && n < 20) begin @(negedge clk); #1; n++; end
      @(posedge clk); @(negedge clk); bus.arvalid = 1'b0;
      bus.rready = 1'b1; @(negedge clk); bus.rready = 1'b0;
      rst = 1'b1; @(negedge clk); rst = 1'b0; #1;
      checks++; if (bus.rvalid !== 1'b0 || bus.arready !== 1'b1) begin failures++; $display("FAIL rstmid_read got=%b/%b exp=0/1", bus.rvalid, bus.arready); end
      fill_normal(3);
      bus.awid = 4'h3; bus.awaddr = 32'h80; bus.awlen = 4'd3; bus.awvalid = 1'b1;
      @(posedge clk); @(negedge clk); bus.awvalid = 1'b0;
      for (int b = 0; b < 2; b++) begin
         bus.wdata = wd[b]; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1; @(negedge clk);
      end
      bus.wvalid = 1'b0; model_write(32'h80, 1);
      rst = 1'b1; @(negedge clk); rst = 1'b0;
      stab = 1;
      repeat (4) begin @(negedge clk); if (bus.bvalid !== 1'b0 || bus.wready !== 1'b0) stab = 0; end
      checks++; if (stab !== 1'b1) begin failures++; $display("FAIL rstmid_write_no_b got=%0d exp=1", stab); end
      axi_read(32'h80, 3, 4'h1, -1, to, lat, stab, endk);
      for (int b = 0; b < 4; b++) begin
         checks++; if (rd_data[b] !== mm[32 + b]) begin failures++; $display("FAIL rstmid_keep%0d got=%h exp=%h", b, rd_data[b], mm[32 + b]); end
      end
   endtask

   task automatic test_random;
      logic [31:0] a; int len; logic [3:0] id; int base;
      for (int it = 0; it < 40; it++) begin
         a = $urandom; a[13:2] = 12'($urandom_range(0, 240));
         len = $urandom_range(0, 15); id = 4'($urandom); base = int'(a[13:2]);
         if ($urandom_range(0, 1) == 1) begin
            fill_normal(len);
            for (int b = 0; b <= len; b++) ws[b] = 4'($urandom);
            if ($urandom_range(0, 4) == 0) wl[$urandom_range(0, len)] ^= 1'b1;
            axi_write(a, len, id, br, bi, to); model_write(a, len);
            checks++; if (to || br !== exp_bresp(len) || bi !== id) begin
               failures++; $display("FAIL rand_wr%0d got=%b/%h exp=%b/%h", it, br, bi, exp_bresp(len), id); end
         end else begin
            axi_read(a, len, id, -1, to, lat, stab, endk);
            checks++; if (to || !lat || !stab || !endk) begin failures++; $display("FAIL rand_rd_proto%0d got=%0d%0d%0d%0d exp=0111", it, to, lat, stab, endk); end
            for (int b = 0; b <= len; b++) begin
               checks++; if (rd_data[b] !== mm[base + b] || rd_last[b] !== (b == len) || rd_id[b] !== id) begin
                  failures++; $display("FAIL rand_rd%0d_beat%0d got=%h/%b/%h exp=%h/%b/%h", it, b, rd_data[b], rd_last[b], rd_id[b], mm[base + b], (b == len), id); end
            end
         end
      end
   endtask

   initial begin
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
      test_reset;
      init_region;
      test_single_read;
      test_burst;
      test_strobe;
      test_collision;
      test_wlast_err;
      test_stall;
      test_wrap;
      test_reset_mid;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
